alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 8-bit combinational ALU.
- WIDTH-bit operands, same 3-bit opcode map, with the equal opcode now implemented.
- Adds status flags, a two-stage registered pipeline, and valid/ready handshakes on both sides.
- Sits between the operand-fetch logic and the writeback/flag consumers.

---
 rtl/alu_pipe.sv | 192 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with status flags and valid/ready handshakes on both
// sides. Stage 1 captures operands and opcode; stage 2 holds the result and
// flags computed from stage 1.
//
// Opcodes: 000 add, 001 sub, 010 sll, 011 srl, 100 and, 101 or, 110 xor,
//          111 eq ({WIDTH-1 zeros, a==b}).
//
// Configuration macro:
//   ALU_SAT_EN  when defined, add saturates to all-ones on carry-out and sub
//               saturates to zero on borrow. Undefined: add/sub wrap.
//
// Parameters:
//   WIDTH       operand/result width, 4..64
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand/opcode presented
//   in_ready_o   input accepted this cycle when in_valid_i is also high
//   a_i, b_i     operands (b_i is also the shift amount)
//   op_i         opcode
//   out_valid_o  result and flags valid
//   out_ready_i  consumer accepts the result this cycle
//   alu_o        result
//   zero_o       alu_o == 0
//   carry_o      add carry-out / sub borrow, 0 for other ops
//   neg_o        alu_o[WIDTH-1]
//   ovf_o        signed overflow for add/sub, 0 for other ops
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             neg_o,
    output logic             ovf_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at the rising edge. Valid never depends on ready; in_ready_o depends
    // only on pipeline state and out_ready_i, never on in_valid_i.

    // Stage 1: captured operands
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;

    // Stage 2: result and flags
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_res_q;
    logic             s2_zero_q;
    logic             s2_carry_q;
    logic             s2_neg_q;
    logic             s2_ovf_q;

    logic s2_load;
    logic in_accept;

    // S2 can take new content when empty or when its current content leaves.
    assign s2_load    = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s2_load;
    assign in_accept  = in_valid_i && in_ready_o;

    // Execute stage (combinational from S1)
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             shift_oversize;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic             zero_d;
    logic             neg_d;

    always_comb begin
        sum_w          = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff_w         = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        // Covers both set upper bits and in-range encodings >= WIDTH when
        // WIDTH is not a power of two.
        shift_oversize = (s1_b_q >= WIDTH_V);
        shamt          = s1_b_q[SHW-1:0];
        res_d          = '0;
        carry_d        = 1'b0;
        ovf_d          = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                carry_d = sum_w[WIDTH];
                ovf_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
`ifdef ALU_SAT_EN
                res_d   = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
                res_d   = sum_w[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // MSB of the (WIDTH+1)-bit difference is the unsigned borrow.
                carry_d = diff_w[WIDTH];
                ovf_d   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
`ifdef ALU_SAT_EN
                res_d   = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
`else
                res_d   = diff_w[WIDTH-1:0];
`endif
            end
            OP_SLL:  res_d = shift_oversize ? '0 : (s1_a_q << shamt);
            OP_SRL:  res_d = shift_oversize ? '0 : (s1_a_q >> shamt);
            OP_AND:  res_d = s1_a_q & s1_b_q;
            OP_OR:   res_d = s1_a_q | s1_b_q;
            OP_XOR:  res_d = s1_a_q ^ s1_b_q;
            OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
            default: res_d = '0;
        endcase
        zero_d = (res_d == '0);
        neg_d  = res_d[WIDTH-1];
    end

    // Stage 1 register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
        end else if (in_accept) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= a_i;
            s1_b_q     <= b_i;
            s1_op_q    <= op_i;
        end else if (s2_load) begin
            // S1 content moved to S2 and nothing replaced it.
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2 register; payload only changes when a real op moves in, so the
    // outputs are stable across stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_carry_q <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q   <= res_d;
                s2_zero_q  <= zero_d;
                s2_carry_q <= carry_d;
                s2_neg_q   <= neg_d;
                s2_ovf_q   <= ovf_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign alu_o       = s2_res_q;
    assign zero_o      = s2_zero_q;
    assign carry_o     = s2_carry_q;
    assign neg_o       = s2_neg_q;
    assign ovf_o       = s2_ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//
// Bench for alu_pipe at WIDTH=8 (streaming, backpressure, reset) and WIDTH=16
// (single-op lockstep). Expected values come from an arithmetic reference
// model; the WIDTH=8 instance is tracked by an expected queue in a monitor.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, alu;
    logic [2:0] op;
    logic       zero, carry, neg, ovf;

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .op_i(op),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .alu_o(alu), .zero_o(zero), .carry_o(carry), .neg_o(neg), .ovf_o(ovf)
    );

    // ---------------- WIDTH=16 instance ----------------
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, alu16;
    logic [2:0]  op16;
    logic        zero16, carry16, neg16, ovf16;

    alu_pipe #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid16), .in_ready_o(in_ready16),
        .a_i(a16), .b_i(b16), .op_i(op16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready16),
        .alu_o(alu16), .zero_o(zero16), .carry_o(carry16), .neg_o(neg16), .ovf_o(ovf16)
    );

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int n_out        = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {ovf, neg, carry, zero, result[63:0]} for a w-bit ALU (w <= 32).
    function automatic logic [67:0] ref_alu(input logic [2:0] o, input longint unsigned av,
                                            input longint unsigned bv, input int w);
        longint unsigned modv, mask, r;
        longint          sa, sb, s, half;
        logic [63:0]     rv;
        bit              c, v;
        modv = 64'd1 << w;
        mask = modv - 1;
        half = longint'(modv / 2);
        sa   = (av >= modv / 2) ? longint'(av) - longint'(modv) : longint'(av);
        sb   = (bv >= modv / 2) ? longint'(bv) - longint'(modv) : longint'(bv);
        r = 0; c = 0; v = 0; s = 0;
        case (o)
            3'd0: begin
                r = av + bv;
                c = (r >= modv);
                s = sa + sb;
                v = (s >= half) || (s < -half);
`ifdef ALU_SAT_EN
                if (c) r = mask;
`endif
                r = r & mask;
            end
            3'd1: begin
                c = (av < bv);
                s = sa - sb;
                v = (s >= half) || (s < -half);
                r = (av - bv) & mask;
`ifdef ALU_SAT_EN
                if (c) r = 0;
`endif
            end
            3'd2: r = (bv >= longint'(w)) ? 0 : ((av << bv) & mask);
            3'd3: r = (bv >= longint'(w)) ? 0 : (av >> bv);
            3'd4: r = av & bv;
            3'd5: r = av | bv;
            3'd6: r = av ^ bv;
            default: r = (av == bv) ? 1 : 0;
        endcase
        rv = r;
        return {v, rv[w-1], c, (r == 0), rv};
    endfunction

    function automatic logic [11:0] pack8(input logic [67:0] m);
        return {m[67:64], m[7:0]};
    endfunction

    // ---------------- scoreboard / monitor for WIDTH=8 ----------------
    logic [11:0] exp_q[$];
    logic [11:0] prev_out;
    logic        prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1'b1);
                check_eq("hold_data", {ovf, neg, carry, zero, alu}, prev_out);
            end
            check_eq("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            if (exp_q.size() == 0)
                check_eq("idle_valid", out_valid, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", {ovf, neg, carry, zero, alu}, e);
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(pack8(ref_alu(op, 64'(a), 64'(b), 8)));
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovf, neg, carry, zero, alu};
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1.
    task automatic idle8(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Single op on an empty pipe with constant expectations; ef = {ovf,neg,carry,zero}.
    task automatic dir8(input string tag, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] er, input logic [3:0] ef);
        in_valid = 1'b1; op = o; a = av; b = bv; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_res"}, alu, er);
        check_eq({tag, "_flags"}, {ovf, neg, carry, zero}, ef);
    endtask

    task automatic run16(input string tag, input logic [2:0] o, input logic [15:0] av,
                         input logic [15:0] bv);
        logic [67:0] m;
        m = ref_alu(o, 64'(av), 64'(bv), 16);
        in_valid16 = 1'b1; op16 = o; a16 = av; b16 = bv; out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check_eq({tag, "_lat1"}, out_valid16, 1'b0);
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, out_valid16, 1'b1);
        check_eq({tag, "_res"}, alu16, m[15:0]);
        check_eq({tag, "_flags"}, {ovf16, neg16, carry16, zero16}, m[67:64]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c, sent, start_out, guard;
        logic acc;

        in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; out_ready16 = 1'b1;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs8", {out_valid, alu, zero, carry, neg, ovf}, '0);
        check_eq("reset_outs16", {out_valid16, alu16, zero16, carry16, neg16, ovf16}, '0);
        rst_n = 1'b1;
        check_eq("reset_rdy8", in_ready, 1'b1);
        check_eq("reset_rdy16", in_ready16, 1'b1);

        // Directed WIDTH=8 cases
`ifdef ALU_SAT_EN
        dir8("add_carry", 3'b000, 8'hF0, 8'h20, 8'hFF, 4'b0110);
        dir8("sub_borrow", 3'b001, 8'h05, 8'h07, 8'h00, 4'b0011);
`else
        dir8("add_carry", 3'b000, 8'hF0, 8'h20, 8'h10, 4'b0010);
        dir8("sub_borrow", 3'b001, 8'h05, 8'h07, 8'hFE, 4'b0110);
`endif
        dir8("add_ovf", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1100);
        dir8("sub_ovf", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b1000);
        dir8("sll_1", 3'b010, 8'h81, 8'h01, 8'h02, 4'b0000);
        dir8("srl_7", 3'b011, 8'h81, 8'h07, 8'h01, 4'b0000);
        dir8("sll_8", 3'b010, 8'hFF, 8'h08, 8'h00, 4'b0001);
        dir8("srl_80", 3'b011, 8'hFF, 8'h80, 8'h00, 4'b0001);
        dir8("and", 3'b100, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        dir8("or", 3'b101, 8'hF0, 8'h3C, 8'hFC, 4'b0100);
        dir8("xor", 3'b110, 8'hF0, 8'h3C, 8'hCC, 4'b0100);
        dir8("eq_same", 3'b111, 8'h5A, 8'h5A, 8'h01, 4'b0000);
        dir8("eq_diff", 3'b111, 8'h5A, 8'h5B, 8'h00, 4'b0001);
        idle8(2);

        // 10-op stream, consumer stalls cycles 3..6
        c = 0; sent = 0; start_out = n_out;
        while ((n_out - start_out) < 10 && c < 40) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 10);
            a  = 8'($urandom);
            b  = 8'($urandom_range(0, 9));
            op = 3'($urandom_range(0, 7));
            #1;
            if (c == 3) check_eq("stall_in_ready", in_ready, 1'b0);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            c++;
        end
        check_eq("stream_sent", sent, 10);
        check_eq("stream_cycles", c, 16);
        idle8(2);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = (op == 3'b010 || op == 3'b011) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
        idle8(1);

        // Reset with two ops in flight
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b000; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        a = 8'h33; b = 8'h44;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("inflight_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async", {out_valid, alu, zero, carry, neg, ovf}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("rst_rel_rdy", in_ready, 1'b1);
        check_eq("rst_rel_valid", out_valid, 1'b0);
        dir8("post_rst", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1100);
        idle8(2);

        // WIDTH=16
`ifdef ALU_SAT_EN
        in_valid16 = 1'b1; op16 = 3'b000; a16 = 16'hFFFF; b16 = 16'h0001;
        @(posedge clk); #1; in_valid16 = 1'b0;
        @(posedge clk); #1;
        check_eq("w16_add_res", alu16, 16'hFFFF);
        check_eq("w16_add_flags", {ovf16, neg16, carry16, zero16}, 4'b0110);
`else
        in_valid16 = 1'b1; op16 = 3'b000; a16 = 16'hFFFF; b16 = 16'h0001;
        @(posedge clk); #1; in_valid16 = 1'b0;
        @(posedge clk); #1;
        check_eq("w16_add_res", alu16, 16'h0000);
        check_eq("w16_add_flags", {ovf16, neg16, carry16, zero16}, 4'b0011);
`endif
        run16("w16_sub", 3'b001, 16'h0005, 16'h0007);
        run16("w16_ovf", 3'b000, 16'h7FFF, 16'h0001);
        run16("w16_sll", 3'b010, 16'h8001, 16'h0001);
        run16("w16_srl15", 3'b011, 16'h8001, 16'h000F);
        run16("w16_sll16", 3'b010, 16'hFFFF, 16'h0010);
        run16("w16_srl100", 3'b011, 16'hFFFF, 16'h0100);
        run16("w16_eq", 3'b111, 16'hA55A, 16'hA55A);
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 7));
            run16("w16_rand", ro, 16'($urandom),
                  (ro == 3'b010 || ro == 3'b011) ? 16'($urandom_range(0, 20)) : 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
